// File: rtl/w_grf.sv
// rtl/w_grf.sv - MIPS writeback stage with 32x32 register file and W->D bypass
module w_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_Instr,
    input  logic [31:0] W_ALUresult,
    input  logic [31:0] W_RD,
    input  logic [4:0]  D_rA1,
    input  logic [4:0]  D_rA2,
    output logic [31:0] D_RD1,
    output logic [31:0] D_RD2,
    output logic        W_we,
    output logic [4:0]  W_wa,
    output logic [31:0] W_wd
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [9:0]  unused_instr_bits;

    logic [31:0] grf_q [32];
    logic [31:0] grf_d [32];

    assign op    = W_Instr[31:26];
    assign funct = W_Instr[5:0];
    assign rt    = W_Instr[20:16];
    assign rd    = W_Instr[15:11];
    assign unused_instr_bits = {W_Instr[25:21], W_Instr[10:6]};

    always_comb begin
        case (W_ALUresult[1:0])
            2'd0:    byte_sel = W_RD[7:0];
            2'd1:    byte_sel = W_RD[15:8];
            2'd2:    byte_sel = W_RD[23:16];
            default: byte_sel = W_RD[31:24];
        endcase
        half_sel = W_ALUresult[1] ? W_RD[31:16] : W_RD[15:0];
    end

    // W_we is reported before the $0 filter so the hazard unit sees the raw decode.
    always_comb begin
        W_we = 1'b0;
        W_wa = 5'd0;
        W_wd = 32'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B: begin
                        W_we = 1'b1;
                        W_wa = rd;
                        W_wd = W_ALUresult;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = W_ALUresult;
            end
            OP_LB: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = {24'd0, byte_sel};
            end
            OP_LH: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = {16'd0, half_sel};
            end
            OP_LW: begin
                W_we = 1'b1;
                W_wa = rt;
                W_wd = W_RD;
            end
            OP_JAL: begin
                W_we = 1'b1;
                W_wa = 5'd31;
                W_wd = W_PC + 32'd8;
            end
            default: ;
        endcase
    end

    always_comb begin
        grf_d = grf_q;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_d[i] = 32'd0;
            end
        end else if (W_we && (W_wa != 5'd0)) begin
            grf_d[W_wa] = W_wd;
        end
    end

    always_ff @(posedge clk) begin
        grf_q <= grf_d;
    end

    // Bypass lets the D stage read a value committed at the end of this cycle.
    always_comb begin
        if (D_rA1 == 5'd0) begin
            D_RD1 = 32'd0;
        end else if (!reset && W_we && (W_wa == D_rA1)) begin
            D_RD1 = W_wd;
        end else begin
            D_RD1 = grf_q[D_rA1];
        end
    end

    always_comb begin
        if (D_rA2 == 5'd0) begin
            D_RD2 = 32'd0;
        end else if (!reset && W_we && (W_wa == D_rA2)) begin
            D_RD2 = W_wd;
        end else begin
            D_RD2 = grf_q[D_rA2];
        end
    end
endmodule

// File: tb/tb_w_grf.sv
// tb/tb_w_grf.sv - randomized and directed self-checking bench for w_grf
module tb_w_grf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_PC, W_Instr, W_ALUresult, W_RD;
    logic [4:0]  D_rA1, D_rA2;
    logic [31:0] D_RD1, D_RD2;
    logic        W_we;
    logic [4:0]  W_wa;
    logic [31:0] W_wd;

    int n_cmp  = 0;
    int n_fail = 0;
    logic        check_en = 1'b0;
    logic [31:0] model_grf [32];

    logic [5:0] alu_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B};
    logic [5:0] imm_ops   [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    logic [5:0] load_ops  [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] nowr_ops  [6] = '{6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02};

    w_grf dut (
        .clk(clk), .reset(reset), .W_PC(W_PC), .W_Instr(W_Instr),
        .W_ALUresult(W_ALUresult), .W_RD(W_RD), .D_rA1(D_rA1), .D_rA2(D_rA2),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .W_we(W_we), .W_wa(W_wa), .W_wd(W_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Returns {we, wa, wd} straight from the instruction-class table.
    function automatic logic [37:0] model_wb(input logic [31:0] instr, pc, alu, mem);
        logic [5:0]  op = instr[31:26];
        logic [31:0] b  = (mem >> (8 * alu[1:0])) & 32'hFF;
        logic [31:0] h  = (mem >> (16 * alu[1])) & 32'hFFFF;
        if (op == 6'h00 && instr[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B})
            return {1'b1, instr[15:11], alu};
        if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) return {1'b1, instr[20:16], alu};
        if (op == 6'h20) return {1'b1, instr[20:16], (b >= 32'd128)   ? b - 32'd256   : b};
        if (op == 6'h24) return {1'b1, instr[20:16], b};
        if (op == 6'h21) return {1'b1, instr[20:16], (h >= 32'd32768) ? h - 32'd65536 : h};
        if (op == 6'h25) return {1'b1, instr[20:16], h};
        if (op == 6'h23) return {1'b1, instr[20:16], mem};
        if (op == 6'h03) return {1'b1, 5'd31, pc + 32'd8};
        return 38'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [37:0] wb);
        if (a == 5'd0) return 32'd0;
        if (!reset && wb[37] && wb[36:32] == a) return wb[31:0];
        return model_grf[a];
    endfunction

    always @(posedge clk) begin
        logic [37:0] wb;
        wb = model_wb(W_Instr, W_PC, W_ALUresult, W_RD);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_grf[i] <= 32'd0;
            check_en <= 1'b1;
        end else if (wb[37] && wb[36:32] != 5'd0) begin
            model_grf[wb[36:32]] <= wb[31:0];
        end
    end

    always @(negedge clk) begin
        logic [37:0] wb;
        if (check_en) begin
            wb = model_wb(W_Instr, W_PC, W_ALUresult, W_RD);
            check("model_we", {31'd0, W_we}, {31'd0, wb[37]});
            check("model_wa", {27'd0, W_wa}, {27'd0, wb[36:32]});
            check("model_wd", W_wd, wb[31:0]);
            check("model_rd1", D_RD1, model_read(D_rA1, wb));
            check("model_rd2", D_RD2, model_read(D_rA2, wb));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, pc, alu, mem, input logic [4:0] a1, a2);
        W_Instr = instr; W_PC = pc; W_ALUresult = alu; W_RD = mem; D_rA1 = a1; D_rA2 = a2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] f = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'h00, f[25:6], alu_funct[$urandom_range(0, 5)]};
            1: return {6'h00, f[25:0]};
            2: return {imm_ops[$urandom_range(0, 3)], f[25:0]};
            3: return {load_ops[$urandom_range(0, 4)], f[25:0]};
            4: return {6'h03, f[25:0]};
            5: return {nowr_ops[$urandom_range(0, 5)], f[25:0]};
            6: return f;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cyc();
        reset = 1'b0;
        drive(32'h34050000, 32'd0, 32'h12345678, 32'd0, 5'd5, 5'd0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        mid();
        check("reset_rd1", D_RD1, 32'd0);
        check("bubble_we", {31'd0, W_we}, 32'd0);
        check("bubble_wa", {27'd0, W_wa}, 32'd0);
        check("bubble_wd", W_wd, 32'd0);

        cyc();
        drive(32'h34080000, 32'd0, 32'h0000ABCD, 32'd0, 5'd8, 5'd8);
        mid();
        check("ori_bypass", D_RD1, 32'h0000ABCD);
        cyc();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0);
        mid();
        check("ori_grf", D_RD1, 32'h0000ABCD);

        cyc();
        drive(32'h80090000, 32'd0, 32'd3, 32'h80FF7F01, 5'd9, 5'd0);
        mid(); check("lb_off3", W_wd, 32'hFFFFFF80);
        cyc();
        drive(32'h90090000, 32'd0, 32'd3, 32'h80FF7F01, 5'd9, 5'd0);
        mid(); check("lbu_off3", W_wd, 32'h00000080);
        cyc();
        drive(32'h84090000, 32'd0, 32'd2, 32'h80FF7F01, 5'd9, 5'd0);
        mid(); check("lh_off2", W_wd, 32'hFFFF80FF);
        cyc();
        drive(32'h94090000, 32'd0, 32'd0, 32'h80FF7F01, 5'd9, 5'd0);
        mid(); check("lhu_off0", W_wd, 32'h00007F01);
        cyc();
        drive(32'h8C090000, 32'd0, 32'd1, 32'h80FF7F01, 5'd9, 5'd0);
        mid(); check("lw_off1", W_wd, 32'h80FF7F01);

        cyc();
        drive(32'h0C000100, 32'h00003010, 32'd0, 32'd0, 5'd0, 5'd0);
        cyc();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd0);
        mid(); check("jal_ra", D_RD1, 32'h00003018);
        cyc();
        drive(32'h0C000100, 32'hFFFFFFFC, 32'd0, 32'd0, 5'd0, 5'd0);
        cyc();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd0);
        mid(); check("jal_wrap", D_RD1, 32'h00000004);

        cyc();
        drive(32'h00000020, 32'd0, 32'hDEADBEEF, 32'd0, 5'd0, 5'd0);
        mid();
        check("r0_we", {31'd0, W_we}, 32'd1);
        check("r0_wa", {27'd0, W_wa}, 32'd0);
        check("r0_rd2_during", D_RD2, 32'd0);
        cyc();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        mid(); check("r0_rd2_after", D_RD2, 32'd0);

        foreach (nowr_ops[i]) begin end
        begin
            logic [31:0] nw [3] = '{32'hAC080000, 32'h10000001, 32'h03E00008};
            for (int i = 0; i < 3; i++) begin
                cyc();
                drive(nw[i], 32'h100, 32'h55555555, 32'hAAAAAAAA, 5'd8, 5'd31);
                mid(); check("nowr_we", {31'd0, W_we}, 32'd0);
            end
            cyc();
            drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd31);
            mid();
            check("nowr_r8", D_RD1, 32'h0000ABCD);
            check("nowr_r31", D_RD2, 32'h00000004);
        end

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            cyc();
            ins = rand_instr();
            reset = ($urandom_range(0, 63) == 0);
            drive(ins, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 1) == 1) ? ins[20:16] : 5'($urandom),
                  ($urandom_range(0, 1) == 1) ? ins[15:11] : 5'($urandom));
        end
        cyc();
        reset = 1'b0;
        mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/w_grf.md
# w_grf

Writeback stage plus general register file for the five-stage MIPS pipeline. Sits directly downstream of the M/W pipeline register and consumes its W_PC, W_Instr, W_ALUresult and W_RD outputs. It decodes the W-stage instruction, extracts and extends load data, selects the writeback value, and commits it to a 32×32 register file. Two combinational read ports serve the D stage, with internal W→D bypass.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register addresses.
- clk  input  1  pipeline clock; all register writes on rising edge
- reset  input  1  synchronous, active-high; clears all 32 registers
- W_PC  input  32  PC of the W-stage instruction
- W_Instr  input  32  W-stage instruction word; 0 acts as a bubble
- W_ALUresult  input  32  ALU result; also the load byte address
- W_RD  input  32  aligned word read from data memory in M stage
- D_rA1  input  5  read address, port 1 (rs)
- D_rA2  input  5  read address, port 2 (rt)
- D_RD1  output  32  read data, port 1
- D_RD2  output  32  read data, port 2
- W_we  output  1  W-stage instruction writes a register (decoded, before the $0 filter)
- W_wa  output  5  destination register number; 0 when W_we=0
- W_wd  output  32  writeback data; 0 when W_we=0

## Operation
- Decode uses op = W_Instr[31:26], funct = W_Instr[5:0], rt = [20:16], rd = [15:11].
- Destination and data by instruction class:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sltu 0x2B: wa = rd, wd = W_ALUresult.
  - I-type ALU ops addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F: wa = rt, wd = W_ALUresult.
  - Loads lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25: wa = rt, wd = extended load data.
  - jal 0x03: wa = 31, wd = W_PC + 8 (32-bit wrap).
- All other encodings write nothing. This covers sll/nop, sw, sh, sb, beq, bne, j, jr and unknown opcodes: W_we=0, W_wa=0, W_wd=0.
- Load extraction uses off = W_ALUresult[1:0]:
  - lw: W_RD unchanged. off is ignored.
  - lh/lhu: off[1]=0 selects W_RD[15:0], off[1]=1 selects W_RD[31:16]. off[0] is ignored. lh sign-extends; lhu zero-extends.
  - lb/lbu: selects byte W_RD[8*off+7 : 8*off]. lb sign-extends; lbu zero-extends.
- Commit condition: on rising clk, if reset=0, W_we=1 and W_wa≠0, then GRF[W_wa] <= W_wd. Writes with W_wa=0 are dropped.
- Read ports are combinational. Port 1 uses the following priority; port 2 is identical with D_rA2 and D_RD2:
  - D_rA1 = 0 → D_RD1 = 0.
  - Else reset=0, W_we=1 and W_wa = D_rA1 → D_RD1 = W_wd (bypass).
  - Else D_RD1 = GRF[D_rA1].
- GRF[0] always reads 0, whatever has been written to it.

## Timing
- Reset: on a rising edge with reset=1, all 32 registers become 0. No write occurs in that cycle, and bypass is suppressed while reset is high. A reset asserted mid-stream discards the pending W-stage write.
- Write latency: the value appears in GRF after the rising edge that ends the W-stage cycle.
- Bypass makes that value visible on D_RD1/D_RD2 in the same cycle, with zero latency. This gives correct same-cycle write-then-read without a separate forward.
- W_we, W_wa and W_wd are purely combinational from the W_* inputs. They are valid within the same cycle for the hazard/forward unit.
- Both read ports may address the same register, including the bypassed one. Both then return the same value.
- Only one write per cycle. No internal state other than the 32 registers.

## Test plan
- Reset and bubble:
  - Preload $5 = 0x12345678.
  - Assert reset for 1 cycle.
  - Then hold W_Instr=0 with D_rA1=5.
  - Required: D_RD1=0, W_we=0, W_wa=0, W_wd=0.
- ori plus bypass:
  - Drive W_Instr=0x34080000 (ori $8), W_ALUresult=0x0000ABCD, D_rA1=8.
  - Required: D_RD1=0x0000ABCD in the same cycle.
  - After the edge with W_Instr=0: D_RD1=0x0000ABCD from GRF.
- Load extension, with W_RD=0x80FF7F01:
  - lb, off=3 → 0xFFFFFF80.
  - lbu, off=3 → 0x00000080.
  - lh, off=2 → 0xFFFF80FF.
  - lhu, off=0 → 0x00007F01.
  - lw, off=1 → 0x80FF7F01.
- jal:
  - Drive W_Instr=0x0C000100, W_PC=0x00003010.
  - Required: GRF[31]=0x00003018.
  - Also with W_PC=0xFFFFFFFC: GRF[31]=0x00000004.
- $0 protection:
  - Drive add with rd=0 (W_Instr=0x00000020), W_ALUresult=0xDEADBEEF, D_rA2=0.
  - Required: W_we=1, W_wa=0, D_RD2=0 both during and after the edge.
- Non-writers:
  - Drive sw (0xAC080000), beq (0x10000001) and jr (0x03E00008).
  - Required: W_we=0, and no GRF change across the edges.
